// File: rtl/age_ordered_issue_queue.sv
// Out-of-order issue queue: stores payloads, allocates lowest free entries and
// issues the oldest ready entries through an age matrix (age[r][c]=1: r younger than c).
module age_ordered_issue_queue #(
    parameter int EntryCount = 8,
    parameter int EnqWidth   = 2,
    parameter int IssWidth   = 2,
    parameter int DataWidth  = 32,
    parameter int CntWidth   = $clog2(EntryCount + 1)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [EnqWidth-1:0]                  enq_valid_i,
    output logic [EnqWidth-1:0]                  enq_ready_o,
    input  logic [EnqWidth-1:0][DataWidth-1:0]   enq_data_i,
    output logic [EnqWidth-1:0][EntryCount-1:0]  enq_entry_o,
    input  logic [EntryCount-1:0]                entry_rdy_i,
    output logic [IssWidth-1:0]                  iss_valid_o,
    input  logic [IssWidth-1:0]                  iss_ready_i,
    output logic [IssWidth-1:0][EntryCount-1:0]  iss_entry_o,
    output logic [IssWidth-1:0][DataWidth-1:0]   iss_data_o,
    input  logic                                 flush_i,
    output logic [EntryCount-1:0]                entry_vld_o,
    output logic [CntWidth-1:0]                  count_o,
    output logic                                 full_o,
    output logic                                 empty_o
);

    localparam logic [EntryCount-1:0] One = EntryCount'(1);

    logic [EntryCount-1:0]                 valid;
    logic [EntryCount-1:0][EntryCount-1:0] age;
    logic [DataWidth-1:0]                  payload [EntryCount];
    logic [CntWidth-1:0]                   count;

    logic [EntryCount-1:0]                 avail;
    logic [EntryCount-1:0]                 alloc_mask;
    logic [EnqWidth-1:0]                   enq_fire;
    logic [EntryCount-1:0][EntryCount-1:0] new_row;

    logic [EntryCount-1:0]                 elig;
    logic [CntWidth-1:0]                   rank;
    logic [IssWidth-1:0]                   iss_fire;
    logic [EntryCount-1:0]                 iss_mask;

    // Selection: an eligible entry's rank is the number of older eligible entries
    always_comb begin
        elig        = valid & entry_rdy_i;
        rank        = '0;
        iss_entry_o = '0;
        iss_data_o  = '0;
        iss_valid_o = '0;
        iss_fire    = '0;
        iss_mask    = '0;
        for (int x = 0; x < EntryCount; x++) begin
            rank = CntWidth'($countones(age[x] & elig));
            for (int i = 0; i < IssWidth; i++) begin
                if (elig[x] && rank == CntWidth'(i)) begin
                    iss_entry_o[i][x] = 1'b1;
                    iss_data_o[i]     = iss_data_o[i] | payload[x];
                end
            end
        end
        for (int i = 0; i < IssWidth; i++) begin
            iss_valid_o[i] = $countones(elig) > i;
            iss_fire[i]    = iss_valid_o[i] & iss_ready_i[i];
            if (iss_fire[i]) begin
                iss_mask = iss_mask | iss_entry_o[i];
            end
        end
    end

    // Allocation: each port takes the lowest free entry not claimed by a firing lower port
    always_comb begin
        avail       = ~valid;
        alloc_mask  = '0;
        enq_fire    = '0;
        enq_entry_o = '0;
        enq_ready_o = '0;
        new_row     = '0;
        for (int j = 0; j < EnqWidth; j++) begin
            enq_entry_o[j] = avail & (~avail + One);
            enq_ready_o[j] = |avail;
            enq_fire[j]    = enq_valid_i[j] & enq_ready_o[j];
            if (enq_fire[j]) begin
                for (int r = 0; r < EntryCount; r++) begin
                    if (enq_entry_o[j][r]) begin
                        new_row[r] = (valid & ~iss_mask) | alloc_mask;
                    end
                end
                avail      = avail & ~enq_entry_o[j];
                alloc_mask = alloc_mask | enq_entry_o[j];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
            age   <= '0;
            count <= '0;
        end else if (flush_i) begin
            valid <= '0;
            age   <= '0;
            count <= '0;
        end else begin
            valid <= (valid & ~iss_mask) | alloc_mask;
            count <= count + CntWidth'($countones(enq_fire)) - CntWidth'($countones(iss_fire));
            // A reallocated column must stop claiming seniority over existing entries
            for (int r = 0; r < EntryCount; r++) begin
                for (int c = 0; c < EntryCount; c++) begin
                    if (alloc_mask[r]) begin
                        age[r][c] <= new_row[r][c];
                    end else if (alloc_mask[c]) begin
                        age[r][c] <= 1'b0;
                    end else if (iss_mask[c]) begin
                        age[r][c] <= 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int x = 0; x < EntryCount; x++) begin
            for (int j = 0; j < EnqWidth; j++) begin
                if (enq_fire[j] && enq_entry_o[j][x]) begin
                    payload[x] <= enq_data_i[j];
                end
            end
        end
    end

    assign entry_vld_o = valid;
    assign count_o     = count;
    assign full_o      = (count == CntWidth'(EntryCount));
    assign empty_o     = (count == '0);

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int j = 0; j < EnqWidth; j++) begin
                assert (!(enq_fire[j] && |(enq_entry_o[j] & valid)))
                    else $error("enqueue onto a valid entry");
            end
            for (int i = 0; i < IssWidth; i++) begin
                assert (!(iss_fire[i] && |(iss_entry_o[i] & ~valid)))
                    else $error("issue of an invalid entry");
                assert (!iss_valid_o[i] || $onehot(iss_entry_o[i]))
                    else $error("issue entry not one-hot");
                for (int k = i + 1; k < IssWidth; k++) begin
                    assert (!(iss_valid_o[i] && iss_valid_o[k] && |(iss_entry_o[i] & iss_entry_o[k])))
                        else $error("overlapping issue entries");
                end
            end
            assert (count == CntWidth'($countones(valid)))
                else $error("occupancy does not match valid vector");
        end
    end
`endif

endmodule

// File: tb/tb_age_ordered_issue_queue.sv
// Bench for age_ordered_issue_queue: directed scenarios plus randomized traffic
// checked against an oldest-first list model.
module tb_age_ordered_issue_queue;

    localparam int N  = 8;
    localparam int EW = 2;
    localparam int IW = 2;
    localparam int DW = 32;
    localparam int CW = $clog2(N + 1);

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [EW-1:0]        enq_valid;
    logic [EW-1:0]        enq_ready;
    logic [EW-1:0][DW-1:0] enq_data;
    logic [EW-1:0][N-1:0] enq_entry;
    logic [N-1:0]         entry_rdy;
    logic [IW-1:0]        iss_valid;
    logic [IW-1:0]        iss_ready;
    logic [IW-1:0][N-1:0] iss_entry;
    logic [IW-1:0][DW-1:0] iss_data;
    logic                 flush;
    logic [N-1:0]         entry_vld;
    logic [CW-1:0]        count;
    logic                 full;
    logic                 empty;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    age_ordered_issue_queue #(
        .EntryCount(N), .EnqWidth(EW), .IssWidth(IW), .DataWidth(DW)
    ) dut (
        .clk(clk), .rst(rst),
        .enq_valid_i(enq_valid), .enq_ready_o(enq_ready), .enq_data_i(enq_data),
        .enq_entry_o(enq_entry), .entry_rdy_i(entry_rdy),
        .iss_valid_o(iss_valid), .iss_ready_i(iss_ready), .iss_entry_o(iss_entry),
        .iss_data_o(iss_data), .flush_i(flush), .entry_vld_o(entry_vld),
        .count_o(count), .full_o(full), .empty_o(empty)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        enq_valid = '0;
        enq_data  = '0;
        entry_rdy = '0;
        iss_ready = '0;
        flush     = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
    endtask

    task automatic fill(input int n, input logic [DW-1:0] base);
        for (int k = 0; k < n; k += 2) begin
            enq_valid   = (n - k >= 2) ? 2'b11 : 2'b01;
            enq_data[0] = base + DW'(k);
            enq_data[1] = base + DW'(k + 1);
            tick();
        end
        enq_valid = '0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        entry_rdy = '1;
        @(posedge clk);
        #1;
        total++; if (count !== 4'd0) $display("[TB] FAIL reset_count got %0d want 0", count); else passed++;
        total++; if (empty !== 1'b1) $display("[TB] FAIL reset_empty got %b want 1", empty); else passed++;
        total++; if (full !== 1'b0) $display("[TB] FAIL reset_full got %b want 0", full); else passed++;
        total++; if (iss_valid !== 2'b00) $display("[TB] FAIL reset_iss_valid got %b want 00", iss_valid); else passed++;
        total++; if (enq_ready !== 2'b11) $display("[TB] FAIL reset_enq_ready got %b want 11", enq_ready); else passed++;
        total++; if (entry_vld !== 8'h00) $display("[TB] FAIL reset_entry_vld got %h want 00", entry_vld); else passed++;
        rst = 1'b0;
        #1;
    endtask

    task automatic test_basic();
        do_reset();
        entry_rdy = '1;
        enq_valid = 2'b11; enq_data[0] = 32'hA; enq_data[1] = 32'hB;
        #1;
        total++; if (enq_entry[0] !== 8'h01) $display("[TB] FAIL basic_alloc0 got %h want 01", enq_entry[0]); else passed++;
        total++; if (enq_entry[1] !== 8'h02) $display("[TB] FAIL basic_alloc1 got %h want 02", enq_entry[1]); else passed++;
        total++; if (iss_valid !== 2'b00) $display("[TB] FAIL basic_no_same_cycle_issue got %b want 00", iss_valid); else passed++;
        tick();
        enq_valid = 2'b01; enq_data[0] = 32'hC;
        #1;
        total++; if (iss_valid !== 2'b11) $display("[TB] FAIL basic_iss_valid got %b want 11", iss_valid); else passed++;
        total++; if (iss_entry[0] !== 8'h01 || iss_data[0] !== 32'hA) $display("[TB] FAIL basic_port0 got %h/%h want 01/a", iss_entry[0], iss_data[0]); else passed++;
        total++; if (iss_entry[1] !== 8'h02 || iss_data[1] !== 32'hB) $display("[TB] FAIL basic_port1 got %h/%h want 02/b", iss_entry[1], iss_data[1]); else passed++;
        total++; if (enq_entry[0] !== 8'h04) $display("[TB] FAIL basic_alloc_c got %h want 04", enq_entry[0]); else passed++;
        tick();
        enq_valid = '0;
        #1;
        total++; if (count !== 4'd3) $display("[TB] FAIL basic_count got %0d want 3", count); else passed++;
        total++; if (entry_vld !== 8'h07) $display("[TB] FAIL basic_entry_vld got %h want 07", entry_vld); else passed++;
    endtask

    task automatic test_full();
        do_reset();
        entry_rdy = '1;
        fill(8, 32'hD0);
        #1;
        total++; if (count !== 4'd8 || full !== 1'b1) $display("[TB] FAIL full_count got %0d/%b want 8/1", count, full); else passed++;
        total++; if (enq_ready !== 2'b00) $display("[TB] FAIL full_enq_ready got %b want 00", enq_ready); else passed++;
        iss_ready = 2'b11;
        #1;
        total++; if (enq_ready !== 2'b00) $display("[TB] FAIL full_ready_during_issue got %b want 00", enq_ready); else passed++;
        total++; if (iss_entry[0] !== 8'h01 || iss_data[0] !== 32'hD0) $display("[TB] FAIL full_port0 got %h/%h want 01/d0", iss_entry[0], iss_data[0]); else passed++;
        total++; if (iss_entry[1] !== 8'h02 || iss_data[1] !== 32'hD1) $display("[TB] FAIL full_port1 got %h/%h want 02/d1", iss_entry[1], iss_data[1]); else passed++;
        tick();
        iss_ready = '0;
        #1;
        total++; if (count !== 4'd6 || full !== 1'b0) $display("[TB] FAIL full_after_issue got %0d/%b want 6/0", count, full); else passed++;
        total++; if (enq_ready !== 2'b11) $display("[TB] FAIL full_ready_after got %b want 11", enq_ready); else passed++;
        total++; if (entry_vld !== 8'hFC) $display("[TB] FAIL full_entry_vld got %h want fc", entry_vld); else passed++;
        total++; if (iss_entry[0] !== 8'h04 || iss_data[0] !== 32'hD2) $display("[TB] FAIL full_next_oldest got %h/%h want 04/d2", iss_entry[0], iss_data[0]); else passed++;
    endtask

    task automatic test_select();
        do_reset();
        enq_valid = 2'b11; enq_data[0] = 32'hA0; enq_data[1] = 32'hA1; tick();
        enq_valid = 2'b01; enq_data[0] = 32'hA2; tick();
        enq_valid = 2'b00; entry_rdy = 8'h03; iss_ready = 2'b11; tick();
        enq_valid = 2'b11; enq_data[0] = 32'hB0; enq_data[1] = 32'hB1; entry_rdy = '0; iss_ready = '0; tick();
        enq_valid = 2'b01; enq_data[0] = 32'hB3; entry_rdy = 8'h02; iss_ready = 2'b01; tick();
        enq_valid = 2'b01; enq_data[0] = 32'hC1; entry_rdy = '0; iss_ready = '0; tick();
        // age order is now 2,0,3,1
        enq_valid = '0; entry_rdy = 8'h0A;
        #1;
        total++; if (iss_valid !== 2'b11) $display("[TB] FAIL select_valid got %b want 11", iss_valid); else passed++;
        total++; if (iss_entry[0] !== 8'h08 || iss_data[0] !== 32'hB3) $display("[TB] FAIL select_port0 got %h/%h want 08/b3", iss_entry[0], iss_data[0]); else passed++;
        total++; if (iss_entry[1] !== 8'h02 || iss_data[1] !== 32'hC1) $display("[TB] FAIL select_port1 got %h/%h want 02/c1", iss_entry[1], iss_data[1]); else passed++;
        entry_rdy = 8'h0F;
        #1;
        total++; if (iss_entry[0] !== 8'h04 || iss_entry[1] !== 8'h01) $display("[TB] FAIL select_all_ready got %h/%h want 04/01", iss_entry[0], iss_entry[1]); else passed++;
        entry_rdy = 8'h0A; iss_ready = 2'b10;
        tick();
        iss_ready = '0;
        #1;
        total++; if (entry_vld !== 8'h0D) $display("[TB] FAIL select_after_stall got %h want 0d", entry_vld); else passed++;
        total++; if (iss_valid !== 2'b01 || iss_entry[0] !== 8'h08) $display("[TB] FAIL select_remaining got %b/%h want 01/08", iss_valid, iss_entry[0]); else passed++;
    endtask

    task automatic test_sparse();
        do_reset();
        fill(8, 32'h50);
        entry_rdy = 8'hA0; iss_ready = 2'b11;
        #1;
        total++; if (iss_entry[0] !== 8'h20 || iss_entry[1] !== 8'h80) $display("[TB] FAIL sparse_issue got %h/%h want 20/80", iss_entry[0], iss_entry[1]); else passed++;
        tick();
        entry_rdy = '0; iss_ready = '0;
        enq_valid = 2'b10; enq_data[1] = 32'h55;
        #1;
        total++; if (enq_ready !== 2'b11) $display("[TB] FAIL sparse_ready got %b want 11", enq_ready); else passed++;
        total++; if (enq_entry[1] !== 8'h20) $display("[TB] FAIL sparse_alloc1 got %h want 20", enq_entry[1]); else passed++;
        tick();
        enq_valid = '0;
        #1;
        total++; if (entry_vld !== 8'h7F || count !== 4'd7) $display("[TB] FAIL sparse_after got %h/%0d want 7f/7", entry_vld, count); else passed++;
    endtask

    task automatic test_flush();
        do_reset();
        fill(5, 32'hF0);
        entry_rdy = '1; flush = 1'b1; enq_valid = 2'b11; iss_ready = 2'b11;
        #1;
        total++; if (enq_ready !== 2'b11 || iss_valid !== 2'b11) $display("[TB] FAIL flush_not_gated got %b/%b want 11/11", enq_ready, iss_valid); else passed++;
        tick();
        flush = 1'b0; enq_valid = '0; iss_ready = '0;
        #1;
        total++; if (count !== 4'd0 || empty !== 1'b1) $display("[TB] FAIL flush_count got %0d/%b want 0/1", count, empty); else passed++;
        total++; if (entry_vld !== 8'h00 || iss_valid !== 2'b00) $display("[TB] FAIL flush_vld got %h/%b want 00/00", entry_vld, iss_valid); else passed++;
        enq_valid = 2'b01;
        #1;
        total++; if (enq_entry[0] !== 8'h01) $display("[TB] FAIL flush_realloc got %h want 01", enq_entry[0]); else passed++;
        tick();
        enq_valid = '0;
    endtask

    task automatic test_async_reset();
        do_reset();
        fill(4, 32'h40);
        entry_rdy = '1;
        #2;
        rst = 1'b1;
        #1;
        total++; if (count !== 4'd0 || entry_vld !== 8'h00) $display("[TB] FAIL async_reset got %0d/%h want 0/00", count, entry_vld); else passed++;
        total++; if (iss_valid !== 2'b00 || empty !== 1'b1) $display("[TB] FAIL async_reset_iss got %b/%b want 00/1", iss_valid, empty); else passed++;
        rst = 1'b0;
        #1;
    endtask

    task automatic test_random();
        int ord_idx[$];
        logic [DW-1:0] ord_data[$];
        int new_idx[$];
        logic [DW-1:0] new_data[$];
        int elist[$];
        logic [N-1:0] mvld;
        logic [N-1:0] onehot;
        logic [IW-1:0] removed;
        int nfree, fired, seen, idx;
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            enq_valid   = EW'($urandom);
            enq_data[0] = $urandom;
            enq_data[1] = $urandom;
            entry_rdy   = N'($urandom);
            iss_ready   = IW'($urandom);
            flush       = ($urandom_range(0, 63) == 0);
            #1;
            mvld = '0;
            foreach (ord_idx[k]) mvld[ord_idx[k]] = 1'b1;
            nfree = N - ord_idx.size();
            fired = 0;
            new_idx.delete();
            new_data.delete();
            for (int j = 0; j < EW; j++) begin
                total++; if (enq_ready[j] !== (nfree > fired)) $display("[TB] FAIL rand_enq_ready%0d cyc %0d got %b want %b", j, cyc, enq_ready[j], nfree > fired); else passed++;
                if (nfree > fired) begin
                    seen = 0; idx = 0;
                    for (int e = 0; e < N; e++) begin
                        if (!mvld[e]) begin
                            if (seen == fired) idx = e;
                            seen++;
                        end
                    end
                    onehot = '0; onehot[idx] = 1'b1;
                    total++; if (enq_entry[j] !== onehot) $display("[TB] FAIL rand_enq_entry%0d cyc %0d got %h want %h", j, cyc, enq_entry[j], onehot); else passed++;
                    if (enq_valid[j]) begin
                        new_idx.push_back(idx);
                        new_data.push_back(enq_data[j]);
                        fired++;
                    end
                end
            end
            elist.delete();
            foreach (ord_idx[k]) if (entry_rdy[ord_idx[k]]) elist.push_back(k);
            removed = '0;
            for (int i = 0; i < IW; i++) begin
                total++; if (iss_valid[i] !== (elist.size() > i)) $display("[TB] FAIL rand_iss_valid%0d cyc %0d got %b want %b", i, cyc, iss_valid[i], elist.size() > i); else passed++;
                if (elist.size() > i) begin
                    onehot = '0; onehot[ord_idx[elist[i]]] = 1'b1;
                    total++; if (iss_entry[i] !== onehot || iss_data[i] !== ord_data[elist[i]]) $display("[TB] FAIL rand_issue%0d cyc %0d got %h/%h want %h/%h", i, cyc, iss_entry[i], iss_data[i], onehot, ord_data[elist[i]]); else passed++;
                    removed[i] = iss_ready[i];
                end
            end
            total++; if (count !== CW'(ord_idx.size()) || entry_vld !== mvld) $display("[TB] FAIL rand_state cyc %0d got %0d/%h want %0d/%h", cyc, count, entry_vld, ord_idx.size(), mvld); else passed++;
            total++; if (full !== (ord_idx.size() == N) || empty !== (ord_idx.size() == 0)) $display("[TB] FAIL rand_flags cyc %0d got %b/%b want %b/%b", cyc, full, empty, ord_idx.size() == N, ord_idx.size() == 0); else passed++;
            tick();
            if (flush) begin
                ord_idx.delete();
                ord_data.delete();
            end else begin
                for (int i = IW - 1; i >= 0; i--) begin
                    if (removed[i]) begin
                        ord_idx.delete(elist[i]);
                        ord_data.delete(elist[i]);
                    end
                end
                foreach (new_idx[k]) begin
                    ord_idx.push_back(new_idx[k]);
                    ord_data.push_back(new_data[k]);
                end
            end
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_basic();
        test_full();
        test_select();
        test_sparse();
        test_flush();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
